vram_arbiter: RTL and testbench

//  Shares one single-port video RAM (iCE40 SPRAM, 1-cycle read latency) between the scan-out

---
 rtl/vram_arbiter_pkg.sv | 30 +++
 rtl/vram_rd_pipe.sv | 66 ++++++
 rtl/vram_arbiter.sv | 111 +++++++++++
 tb/tb_vram_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared widths, SVGA line constants, FSM/owner encodings and tag layout
package vram_arbiter_pkg;
   localparam int ADDR_W = 14;
   localparam int DATA_W = 16;
   localparam int LB_AW = 8;
   localparam int H_ACTIVE = 800;
   localparam int H_FP = 40;
   localparam int H_SYNC = 128;
   localparam int H_BP = 88;
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_ACTIVE = 600;
   localparam int V_FP = 1;
   localparam int V_SYNC = 4;
   localparam int V_BP = 23;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int BPP = 4;
   // one active line packed into VRAM words
   localparam int BURST_LEN = H_ACTIVE * BPP / DATA_W;
   typedef enum logic {ST_IDLE, ST_FETCH} state_e;
   typedef enum logic {OWN_FETCH, OWN_HOST} owner_e;
   typedef struct packed {
      logic             valid;
      owner_e           owner;
      logic             bank;
      logic [LB_AW-1:0] idx;
   } tag_t;
   function automatic logic is_last(input logic [LB_AW-1:0] idx);
      return idx == LB_AW'(BURST_LEN - 1);
   endfunction
endpackage

// File: rtl/vram_rd_pipe.sv
// vram_rd_pipe: two-stage tag pipe that routes each VRAM read word to the line buffer or the host
//   clk, rst            clock, synchronous active-high reset
//   i_tag_*             tag of the access presented to VRAM in the next cycle
//   i_mem_rdata         VRAM read data (one cycle after the address)
//   o_lb_we/addr/wdata  line-buffer write port
//   o_fetch_done        pulse with the last line-buffer write of a burst
//   o_host_rvalid/rdata host read return, data held until the next return
//   o_fetch_tail        a fetch word is still in flight
module vram_rd_pipe
   import vram_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_tag_valid,
   input  logic              i_tag_host,
   input  logic              i_tag_bank,
   input  logic [LB_AW-1:0]  i_tag_idx,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_lb_we,
   output logic [LB_AW:0]    o_lb_addr,
   output logic [DATA_W-1:0] o_lb_wdata,
   output logic              o_fetch_done,
   output logic              o_host_rvalid,
   output logic [DATA_W-1:0] o_host_rdata,
   output logic              o_fetch_tail
);
   tag_t              r_s1, r_s2;
   logic              r_lb_we, r_done, r_rvalid;
   logic [LB_AW:0]    r_lb_addr;
   logic [DATA_W-1:0] r_lb_wdata, r_rdata;
   logic              w_fetch1, w_fetch2, w_host2;
   // stage 1 matches the cycle the address is on mem_*, stage 2 the cycle its data returns
   assign w_fetch1 = r_s1.valid & (r_s1.owner == OWN_FETCH);
   assign w_fetch2 = r_s2.valid & (r_s2.owner == OWN_FETCH);
   assign w_host2 = r_s2.valid & (r_s2.owner == OWN_HOST);
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1 <= '0;
         r_s2 <= '0;
         r_lb_we <= 1'b0;
         r_lb_addr <= '0;
         r_lb_wdata <= '0;
         r_done <= 1'b0;
         r_rvalid <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_s1 <= '{valid: i_tag_valid, owner: (i_tag_host ? OWN_HOST : OWN_FETCH), bank: i_tag_bank, idx: i_tag_idx};
         r_s2 <= r_s1;
         r_lb_we <= w_fetch2;
         r_done <= w_fetch2 & is_last(r_s2.idx);
         r_rvalid <= w_host2;
         if (w_fetch2) begin
            r_lb_addr <= {r_s2.bank, r_s2.idx};
            r_lb_wdata <= i_mem_rdata;
         end
         if (w_host2) r_rdata <= i_mem_rdata;
      end
   end
   assign o_lb_we = r_lb_we;
   assign o_lb_addr = r_lb_addr;
   assign o_lb_wdata = r_lb_wdata;
   assign o_fetch_done = r_done;
   assign o_host_rvalid = r_rvalid;
   assign o_host_rdata = r_rdata;
   assign o_fetch_tail = w_fetch1 | w_fetch2 | r_lb_we;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM between the scan-out line fetcher and a host port
//   clk, rst                      pixel clock, synchronous active-high reset
//   i_fetch_start/base/bank       line-fetch request (base and bank sampled with start)
//   o_fetch_busy/done/ovr         fetch status; ovr is sticky until reset
//   o_lb_we/addr/wdata            line-buffer write port, addr = {bank, word index}
//   i_host_valid/we/addr/wdata    host request, accepted on valid & o_host_ready
//   o_host_rvalid/rdata           host read return
//   o_mem_addr/we/wdata           registered VRAM controls
//   i_mem_rdata                   VRAM read data, one cycle after the address
module vram_arbiter
   import vram_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_fetch_start,
   input  logic [ADDR_W-1:0] i_fetch_base,
   input  logic              i_fetch_bank,
   output logic              o_fetch_busy,
   output logic              o_fetch_done,
   output logic              o_fetch_ovr,
   output logic              o_lb_we,
   output logic [LB_AW:0]    o_lb_addr,
   output logic [DATA_W-1:0] o_lb_wdata,
   input  logic              i_host_valid,
   output logic              o_host_ready,
   input  logic              i_host_we,
   input  logic [ADDR_W-1:0] i_host_addr,
   input  logic [DATA_W-1:0] i_host_wdata,
   output logic              o_host_rvalid,
   output logic [DATA_W-1:0] o_host_rdata,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_we,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);
   state_e            r_state;
   logic [LB_AW-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_base, r_mem_addr;
   logic              r_bank, r_mem_we, r_ovr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              w_idle, w_start, w_accept, w_last, w_tail;
   logic              w_tag_valid, w_tag_host, w_tag_bank;
   logic [LB_AW-1:0]  w_next_cnt, w_tag_idx;
   assign w_idle = r_state == ST_IDLE;
   assign w_start = w_idle & i_fetch_start;
   assign o_host_ready = ~rst & w_idle & ~i_fetch_start;
   assign w_accept = i_host_valid & o_host_ready;
   // r_cnt is the index of the word currently on mem_*
   assign w_last = is_last(r_cnt);
   assign w_next_cnt = r_cnt + 1'b1;
   // tag for the access that goes onto mem_* at the next edge; host writes return nothing
   assign w_tag_valid = w_start | ((r_state == ST_FETCH) & ~w_last) | (w_accept & ~i_host_we);
   assign w_tag_host = w_idle & ~w_start;
   assign w_tag_bank = w_start ? i_fetch_bank : r_bank;
   assign w_tag_idx = w_start ? '0 : w_next_cnt;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt <= '0;
         r_base <= '0;
         r_bank <= 1'b0;
         r_mem_addr <= '0;
         r_mem_we <= 1'b0;
         r_mem_wdata <= '0;
         r_ovr <= 1'b0;
      end else begin
         r_mem_we <= 1'b0;
         if (r_state == ST_FETCH && i_fetch_start) r_ovr <= 1'b1;
         if (r_state == ST_IDLE) begin
            if (i_fetch_start) begin
               r_state <= ST_FETCH;
               r_cnt <= '0;
               r_base <= i_fetch_base;
               r_bank <= i_fetch_bank;
               r_mem_addr <= i_fetch_base;
            end else if (w_accept) begin
               r_mem_addr <= i_host_addr;
               r_mem_we <= i_host_we;
               r_mem_wdata <= i_host_wdata;
            end
         end else if (w_last) begin
            r_state <= ST_IDLE;
         end else begin
            r_cnt <= w_next_cnt;
            r_mem_addr <= r_base + ADDR_W'(w_next_cnt);
         end
      end
   end
   vram_rd_pipe u_rd_pipe (
      .clk           (clk),
      .rst           (rst),
      .i_tag_valid   (w_tag_valid),
      .i_tag_host    (w_tag_host),
      .i_tag_bank    (w_tag_bank),
      .i_tag_idx     (w_tag_idx),
      .i_mem_rdata   (i_mem_rdata),
      .o_lb_we       (o_lb_we),
      .o_lb_addr     (o_lb_addr),
      .o_lb_wdata    (o_lb_wdata),
      .o_fetch_done  (o_fetch_done),
      .o_host_rvalid (o_host_rvalid),
      .o_host_rdata  (o_host_rdata),
      .o_fetch_tail  (w_tail)
   );
   // busy spans the issue phase plus the words still draining through the return pipe
   assign o_fetch_busy = (r_state == ST_FETCH) | w_tail;
   assign o_fetch_ovr = r_ovr;
   assign o_mem_addr = r_mem_addr;
   assign o_mem_we = r_mem_we;
   assign o_mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of fetch bursts, host access, wrap, overrun and reset abort
module tb_vram_arbiter;
   localparam int BL = 200;
   logic        clk = 1'b0, rst = 1'b1;
   logic        fetch_start = 1'b0, fetch_bank = 1'b0;
   logic [13:0] fetch_base = '0;
   logic        fetch_busy, fetch_done, fetch_ovr;
   logic        lb_we;
   logic [8:0]  lb_addr;
   logic [15:0] lb_wdata;
   logic        host_valid = 1'b0, host_we = 1'b0, host_ready;
   logic [13:0] host_addr = '0;
   logic [15:0] host_wdata = '0;
   logic        host_rvalid;
   logic [15:0] host_rdata;
   logic [13:0] mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata, mem_rdata;
   logic [15:0] vram [16384];
   logic [15:0] shadow [16384];
   int          n_vec = 0, n_err = 0, kk = 0;
   bit          exp_ovr = 1'b0;

   vram_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .i_fetch_start (fetch_start),
      .i_fetch_base  (fetch_base),
      .i_fetch_bank  (fetch_bank),
      .o_fetch_busy  (fetch_busy),
      .o_fetch_done  (fetch_done),
      .o_fetch_ovr   (fetch_ovr),
      .o_lb_we       (lb_we),
      .o_lb_addr     (lb_addr),
      .o_lb_wdata    (lb_wdata),
      .i_host_valid  (host_valid),
      .o_host_ready  (host_ready),
      .i_host_we     (host_we),
      .i_host_addr   (host_addr),
      .i_host_wdata  (host_wdata),
      .o_host_rvalid (host_rvalid),
      .o_host_rdata  (host_rdata),
      .o_mem_addr    (mem_addr),
      .o_mem_we      (mem_we),
      .o_mem_wdata   (mem_wdata),
      .i_mem_rdata   (mem_rdata)
   );

   always #5 clk = ~clk;

   // SPRAM model: one-cycle read latency, read-before-write
   always @(posedge clk) begin
      if (mem_we) vram[mem_addr] <= mem_wdata;
      mem_rdata <= vram[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s k=%0d: got %h want %h", tag, kk, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // fetch started in cycle k=0; optional overrun pulse, reset pulse, or held host read of 0x0010
   task automatic run_fetch(input logic [13:0] base, input logic bank, input int ovr_at, input int rst_at, input bit hold);
      bit          ab;
      logic [13:0] ea;
      int          w;
      kk = 0;
      fetch_start = 1'b1;
      fetch_base = base;
      fetch_bank = bank;
      host_valid = hold;
      host_we = 1'b0;
      host_addr = 14'h0010;
      #1;
      chk("ready_at_start", host_ready, 0);
      chk("busy_at_start", fetch_busy, 0);
      for (int k = 1; k <= 206; k++) begin
         tick();
         kk = k;
         fetch_start = (k == ovr_at);
         fetch_base = ~base;
         fetch_bank = ~bank;
         rst = (k == rst_at);
         host_valid = hold && k <= 201;
         #1;
         if (ovr_at > 0 && k > ovr_at) exp_ovr = 1'b1;
         ab = rst_at > 0 && k > rst_at;
         if (ab) exp_ovr = 1'b0;
         chk("ovr", fetch_ovr, exp_ovr);
         chk("busy", fetch_busy, !ab && k <= BL + 2);
         chk("done", fetch_done, !ab && k == BL + 2);
         chk("lb_we", lb_we, !ab && k >= 3 && k <= BL + 2);
         chk("rvalid", host_rvalid, !ab && hold && k == 204);
         chk("ready", host_ready, ab || k > BL);
         chk("mem_we", mem_we, 0);
         if (ab) begin
            chk("mem_addr_rst", mem_addr, 0);
            chk("lb_addr_rst", lb_addr, 0);
            chk("lb_wdata_rst", lb_wdata, 0);
         end else begin
            ea = (hold && k >= 202) ? 14'h0010 : base + 14'(k > BL ? BL - 1 : k - 1);
            chk("mem_addr", mem_addr, ea);
            if (k >= 3 && k <= BL + 2) begin
               w = k - 3;
               ea = base + 14'(w);
               chk("lb_addr", lb_addr, {bank, 8'(w)});
               chk("lb_wdata", lb_wdata, shadow[ea]);
            end
            if (hold && k == 204) chk("rdata", host_rdata, shadow[14'h0010]);
         end
      end
      fetch_start = 1'b0;
      rst = 1'b0;
      host_valid = 1'b0;
   endtask

   initial begin
      for (int a = 0; a < 16384; a++) begin
         vram[a] = 16'(a) ^ 16'hA5A5;
         shadow[a] = 16'(a) ^ 16'hA5A5;
      end
      tick();
      tick();
      chk("rst_ready", host_ready, 0);
      chk("rst_busy", fetch_busy, 0);
      chk("rst_lb_we", lb_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_ovr", fetch_ovr, 0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", host_ready, 1);
      tick();
      run_fetch(14'h0100, 1'b1, 0, 0, 1'b0);
      tick();
      // host write then read back
      kk = 0;
      host_valid = 1'b1;
      host_we = 1'b1;
      host_addr = 14'h0010;
      host_wdata = 16'hBEEF;
      #1;
      chk("wr_ready", host_ready, 1);
      tick();
      host_valid = 1'b0;
      shadow[14'h0010] = 16'hBEEF;
      #1;
      chk("wr_mem_addr", mem_addr, 14'h0010);
      chk("wr_mem_we", mem_we, 1);
      chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
      tick();
      chk("wr_no_rvalid2", host_rvalid, 0);
      tick();
      chk("wr_no_rvalid3", host_rvalid, 0);
      host_valid = 1'b1;
      host_we = 1'b0;
      #1;
      chk("rd_ready", host_ready, 1);
      tick();
      host_valid = 1'b0;
      #1;
      chk("rd_mem_addr", mem_addr, 14'h0010);
      chk("rd_mem_we", mem_we, 0);
      tick();
      chk("rd_rvalid_t2", host_rvalid, 0);
      tick();
      chk("rd_rvalid_t3", host_rvalid, 1);
      chk("rd_rdata", host_rdata, 16'hBEEF);
      tick();
      chk("rd_rvalid_t4", host_rvalid, 0);
      chk("rd_rdata_held", host_rdata, 16'hBEEF);
      tick();
      run_fetch(14'h0200, 1'b0, 0, 0, 1'b1);
      tick();
      run_fetch(14'h3FF0, 1'b1, 0, 0, 1'b0);
      tick();
      run_fetch(14'h0500, 1'b0, 50, 0, 1'b0);
      tick();
      run_fetch(14'h0800, 1'b1, 0, 100, 1'b0);
      tick();
      run_fetch(14'h1000, 1'b0, 0, 0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
